// File: rtl/hex_display_scheduler.sv
// Time-multiplexes one external hex-to-7-segment decoder across NUM_DIGITS digits,
// scanning MSB to LSB and committing the whole display in a single atomic update.
module hex_display_scheduler #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_value,
  input  logic                    blank_lz,
  output logic [3:0]              dec_nibble,
  input  logic [6:0]              dec_seg,
  output logic [7*NUM_DIGITS-1:0] hex_seg,
  output logic                    busy,
  output logic                    scan_done
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX = (REFRESH_DIV > 0) ? CW'(REFRESH_DIV - 1) : '0;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] held_q, held_d;
  logic                    held_blz_q, held_blz_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    seen_nz_q, seen_nz_d;
  logic [7*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [7*NUM_DIGITS-1:0] hex_seg_q, hex_seg_d;
  logic                    scan_done_q, scan_done_d;
  logic [CW-1:0]           rcnt_q, rcnt_d;
  logic                    pend_q, pend_d;

  logic                    refresh_tick;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      held_q      <= '0;
      held_blz_q  <= 1'b0;
      idx_q       <= '0;
      seen_nz_q   <= 1'b0;
      shadow_q    <= '1;
      hex_seg_q   <= '1;
      scan_done_q <= 1'b0;
      rcnt_q      <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      held_blz_q  <= held_blz_d;
      idx_q       <= idx_d;
      seen_nz_q   <= seen_nz_d;
      shadow_q    <= shadow_d;
      hex_seg_q   <= hex_seg_d;
      scan_done_q <= scan_done_d;
      rcnt_q      <= rcnt_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    refresh_tick = (REFRESH_DIV != 0) && (rcnt_q == CNT_MAX);
    rcnt_d       = ((REFRESH_DIV == 0) || refresh_tick) ? '0 : rcnt_q + 1'b1;
    cur_nib      = held_q[4*idx_q +: 4];
    // Leading zeros blank only above digit 0 and only before the first nonzero nibble
    cur_seg      = (held_blz_q && !seen_nz_q && (cur_nib == 4'h0) && (idx_q != '0))
                   ? 7'h7F : dec_seg;

    state_d     = state_q;
    held_d      = held_q;
    held_blz_d  = held_blz_q;
    idx_d       = idx_q;
    seen_nz_d   = seen_nz_q;
    shadow_d    = shadow_q;
    hex_seg_d   = hex_seg_q;
    scan_done_d = 1'b0;
    pend_d      = pend_q;

    unique case (state_q)
      IDLE: begin
        if (upd_valid) begin
          held_d     = upd_value;
          held_blz_d = blank_lz;
          idx_d      = IDX_MSB;
          seen_nz_d  = 1'b0;
          pend_d     = 1'b0;
          state_d    = SCAN;
        end else if (refresh_tick || pend_q) begin
          idx_d      = IDX_MSB;
          seen_nz_d  = 1'b0;
          pend_d     = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        pend_d                = pend_q | refresh_tick;
        shadow_d[7*idx_q +: 7] = cur_seg;
        seen_nz_d             = seen_nz_q | (cur_nib != 4'h0);
        idx_d                 = idx_q - 1'b1;
        // Digit 0 goes straight from the decoder into the commit, not via shadow_q
        if (idx_q == '0) begin
          hex_seg_d   = shadow_d;
          scan_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    upd_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    dec_nibble = (state_q == SCAN) ? cur_nib : 4'h0;
    hex_seg    = hex_seg_q;
    scan_done  = scan_done_q;
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler: a non-refreshing and a refreshing instance, each
// checked every cycle against a transaction-level display model plus literal pins.
module tb_hex_display_scheduler;

  localparam int N = 8;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic             rst0 = 1'b1, v0 = 1'b0, blz0 = 1'b0;
  logic [4*N-1:0]   val0 = '0;
  logic             rdy0, busy0, done0;
  logic [3:0]       nib0;
  logic [6:0]       seg0;
  logic [7*N-1:0]   hex0;

  logic             rst1 = 1'b1, v1 = 1'b0, blz1 = 1'b0;
  logic [4*N-1:0]   val1 = '0;
  logic             rdy1, busy1, done1;
  logic [3:0]       nib1;
  logic [6:0]       seg1;
  logic [7*N-1:0]   hex1;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign seg0 = seg7(nib0);
  assign seg1 = seg7(nib1);

  hex_display_scheduler #(.NUM_DIGITS(N), .REFRESH_DIV(0)) dut0 (
    .Clk(Clk), .Reset(rst0), .upd_valid(v0), .upd_ready(rdy0), .upd_value(val0),
    .blank_lz(blz0), .dec_nibble(nib0), .dec_seg(seg0), .hex_seg(hex0),
    .busy(busy0), .scan_done(done0)
  );

  hex_display_scheduler #(.NUM_DIGITS(N), .REFRESH_DIV(16)) dut1 (
    .Clk(Clk), .Reset(rst1), .upd_valid(v1), .upd_ready(rdy1), .upd_value(val1),
    .blank_lz(blz1), .dec_nibble(nib1), .dec_seg(seg1), .hex_seg(hex1),
    .busy(busy1), .scan_done(done1)
  );

  // Whole-value display rule: strip leading zeros above digit 0 when blanking.
  function automatic logic [7*N-1:0] display(input logic [4*N-1:0] v, input logic blz);
    logic [7*N-1:0] d;
    logic leading;
    d = '1;
    leading = blz;
    for (int i = N - 1; i >= 0; i--) begin
      if (leading && (v[4*i +: 4] == 4'h0) && (i != 0)) d[7*i +: 7] = 7'h7F;
      else begin
        d[7*i +: 7] = seg7(v[4*i +: 4]);
        leading = 1'b0;
      end
    end
    return d;
  endfunction

  typedef struct packed {
    logic           busy;
    logic [31:0]    cnt;
    logic [4*N-1:0] val;
    logic           blz;
    logic [7*N-1:0] disp;
    logic           done;
    logic [31:0]    rcnt;
    logic           pend;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input logic rst, input logic v,
                                input logic [4*N-1:0] value, input logic blz, input int div);
    mdl_t n;
    logic tk;
    n = m;
    if (rst) begin
      n.busy = 1'b0; n.cnt = 0; n.val = '0; n.blz = 1'b0; n.disp = '1;
      n.done = 1'b0; n.rcnt = 0; n.pend = 1'b0;
      return n;
    end
    tk = (div > 0) && (m.rcnt == 32'(div - 1));
    n.rcnt = (div == 0 || tk) ? 32'd0 : m.rcnt + 32'd1;
    n.done = 1'b0;
    if (!m.busy) begin
      if (v) begin
        n.val = value; n.blz = blz; n.busy = 1'b1; n.cnt = 0; n.pend = 1'b0;
      end else if (tk || m.pend) begin
        n.busy = 1'b1; n.cnt = 0; n.pend = 1'b0;
      end
    end else begin
      if (tk) n.pend = 1'b1;
      n.cnt = m.cnt + 32'd1;
      if (n.cnt == 32'(N)) begin
        n.busy = 1'b0; n.disp = display(m.val, m.blz); n.done = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] mnib(input mdl_t m);
    logic [4*N-1:0] v;
    int pos;
    v = m.val;
    pos = N - 1 - int'(m.cnt);
    if (!m.busy) return 4'h0;
    return v[4*pos +: 4];
  endfunction

  mdl_t m0, m1;
  logic chk_en = 1'b0;

  always @(posedge Clk) begin
    m0 = step(m0, rst0, v0, val0, blz0, 0);
    m1 = step(m1, rst1, v1, val1, blz1, 16);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("m_hex0",  64'(hex0),  64'(m0.disp));
      check("m_rdy0",  64'(rdy0),  64'(!m0.busy));
      check("m_busy0", 64'(busy0), 64'(m0.busy));
      check("m_done0", 64'(done0), 64'(m0.done));
      check("m_nib0",  64'(nib0),  64'(mnib(m0)));
      check("m_hex1",  64'(hex1),  64'(m1.disp));
      check("m_rdy1",  64'(rdy1),  64'(!m1.busy));
      check("m_busy1", 64'(busy1), 64'(m1.busy));
      check("m_done1", 64'(done1), 64'(m1.done));
      check("m_nib1",  64'(nib1),  64'(mnib(m1)));
    end
  end

  int done0_n = 0;
  int base1 = 0;
  logic rec1 = 1'b0;
  int done1_t[$];
  always @(negedge Clk) begin
    if (chk_en && done0) done0_n++;
    if (rec1 && done1) done1_t.push_back(cyc - base1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  localparam logic [7*N-1:0] ALL_BLANK = {N{7'h7F}};

  initial begin
    int nd, t0, t1, dn;
    tick();
    chk_en = 1'b1;
    tick();
    rst0 = 1'b0;

    // Idle after reset, no refresh
    ticks(2);
    check("rst_hex", 64'(hex0), 64'(ALL_BLANK));
    check("rst_rdy", 64'(rdy0), 64'd1);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_nib", 64'(nib0), 64'd0);

    // 0xA5 with blanking: commit exactly 8 edges after accept
    dn = done0_n;
    v0 = 1'b1; val0 = 32'h0000_00A5; blz0 = 1'b1;
    tick();
    v0 = 1'b0;
    check("a5_busy", 64'(busy0), 64'd1);
    check("a5_nib7", 64'(nib0), 64'd0);
    ticks(7);
    check("a5_early", 64'(hex0), 64'(ALL_BLANK));
    tick();
    check("a5_hex", 64'(hex0), 64'({{6{7'h7F}}, 7'h08, 7'h12}));
    check("a5_done", 64'(done0), 64'd1);
    check("a5_rdy", 64'(rdy0), 64'd1);
    ticks(2);
    check("a5_pulses", 64'(done0_n - dn), 64'd1);

    // Same value without blanking, then zero with blanking
    v0 = 1'b1; blz0 = 1'b0;
    tick();
    v0 = 1'b0;
    ticks(8);
    check("a5_noblz", 64'(hex0), 64'({{6{7'h40}}, 7'h08, 7'h12}));
    v0 = 1'b1; val0 = '0; blz0 = 1'b1;
    tick();
    v0 = 1'b0;
    ticks(8);
    check("zero_blz", 64'(hex0), 64'({{7{7'h7F}}, 7'h40}));

    // valid held through a scan with a new value
    v0 = 1'b1; val0 = 32'h1234_5678; blz0 = 1'b0;
    tick();
    val0 = 32'h9ABC_DEF0;
    nd = 0; t0 = 0; t1 = 0;
    for (int i = 1; i <= 40 && nd < 2; i++) begin
      tick();
      if (done0) begin
        if (nd == 0) t0 = i; else t1 = i;
        nd++;
      end
    end
    v0 = 1'b0;
    check("held_ndone", 64'(nd), 64'd2);
    check("held_first", 64'(t0), 64'd8);
    check("held_gap", 64'(t1 - t0), 64'd9);
    check("held_hex", 64'(hex0), 64'(display(32'h9ABC_DEF0, 1'b0)));
    ticks(2);

    // Reset during the 4th scan cycle aborts without committing
    v0 = 1'b1; val0 = 32'hFFFF_FFFF; blz0 = 1'b0;
    tick();
    v0 = 1'b0;
    ticks(3);
    dn = done0_n;
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    check("abort_hex", 64'(hex0), 64'(ALL_BLANK));
    check("abort_rdy", 64'(rdy0), 64'd1);
    check("abort_done", 64'(done0), 64'd0);
    ticks(10);
    check("abort_nopulse", 64'(done0_n - dn), 64'd0);
    check("abort_hex2", 64'(hex0), 64'(ALL_BLANK));

    // Refresh instance: ticks act at edges 16, 32, 48 after reset release
    tick();
    rst1 = 1'b0;
    base1 = cyc;
    rec1 = 1'b1;
    ticks(9);
    v1 = 1'b1; val1 = 32'hC0FF_EE00; blz1 = 1'b1;
    tick();
    v1 = 1'b0;
    ticks(21);
    v1 = 1'b1; val1 = 32'h0000_BEEF;
    tick();
    v1 = 1'b0;
    ticks(13);
    rec1 = 1'b0;
    check("rf_nscans", 64'(done1_t.size()), 64'd3);
    if (done1_t.size() == 3) begin
      check("rf_t0", 64'(done1_t[0]), 64'd18);
      check("rf_t1", 64'(done1_t[1]), 64'd27);
      check("rf_t2", 64'(done1_t[2]), 64'd40);
    end
    check("rf_hex", 64'(hex1), 64'({{4{7'h7F}}, 7'h03, 7'h06, 7'h06, 7'h0E}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
